// File: rtl/oka_pkg.sv
// Shared types and helpers for the sequential Karatsuba carry-less multiplier.
package oka_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMulL,
    StMulM,
    StMulH,
    StRed,
    StDone
  } oka_state_t;

  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w - 1;
  endfunction

  localparam int unsigned MaxW  = 64;
  localparam int unsigned MaxPw = prod_w(MaxW);

  // Folds bits [2w-2:w] of prod back into [w-1:0] using x^w = poly.
  function automatic logic [MaxPw-1:0] clmul_reduce(input logic [MaxPw-1:0] prod,
                                                   input logic [MaxW-1:0]  poly,
                                                   input int unsigned      w);
    logic [MaxPw-1:0] r;
    r = prod;
    for (int k = int'(MaxPw) - 1; k >= 0; k--) begin
      if (k >= int'(w) && k <= int'(2 * w) - 2 && r[k]) begin
        r[k] = 1'b0;
        r    = r ^ (MaxPw'(poly) << (k - int'(w)));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/oka_mul_seq_if.sv
// Operand/result handshake bundle for oka_mul_seq.
interface oka_mul_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-2:0]   y;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/oka_clmul_half.sv
// Combinational HW x HW carry-less multiplier (AND/XOR array).
module oka_clmul_half #(
  parameter int unsigned HW = 8
) (
  input  logic [HW-1:0]   a_i,
  input  logic [HW-1:0]   b_i,
  output logic [2*HW-2:0] p_o
);
  always_comb begin
    p_o = '0;
    for (int i = 0; i < int'(HW); i++) begin
      for (int j = 0; j < int'(HW); j++) begin
        p_o[i+j] = p_o[i+j] ^ (a_i[i] & b_i[j]);
      end
    end
  end
endmodule

// File: rtl/oka_mul_seq.sv
// Sequential one-level Karatsuba GF(2)[x] multiplier sharing one half-width multiplier.
// Define OKA_MOD_REDUCE_EN to add the GF(2^W) reduction step (RED state).
module oka_mul_seq
  import oka_pkg::*;
#(
  parameter int unsigned     WIDTH = 16,
  parameter logic [MaxW-1:0] POLY  = MaxW'(16'h002B)
) (
  input logic          clk,
  input logic          rst,
  oka_mul_seq_if.slave mul_io
);
  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned SW = WIDTH - 1;
  localparam int unsigned PW = prod_w(WIDTH);

  if (WIDTH < 8 || WIDTH > MaxW || (WIDTH & (WIDTH - 1)) != 0 || (POLY >> WIDTH) != '0)
  begin : g_bad_cfg
    $error("oka_mul_seq: WIDTH must be a power of two in [8,64] and POLY must fit in WIDTH");
  end

  oka_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [SW-1:0]    z0_q, z1_q;
  logic [PW-1:0]    y_q;
  logic             in_ready_q, out_valid_q;

  logic [H-1:0]  mul_a, mul_b;
  logic [SW-1:0] half_p, mid;
  logic [PW-1:0] y_mul;

  always_comb begin
    mul_a = a_q[WIDTH-1:H];
    mul_b = b_q[WIDTH-1:H];
    case (state_q)
      StMulL: begin
        mul_a = a_q[H-1:0];
        mul_b = b_q[H-1:0];
      end
      StMulM: begin
        mul_a = a_q[H-1:0] ^ a_q[WIDTH-1:H];
        mul_b = b_q[H-1:0] ^ b_q[WIDTH-1:H];
      end
      default: ;
    endcase
  end

  oka_clmul_half #(
    .HW (H)
  ) u_half (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (half_p)
  );

  // In MUL_H the shared multiplier output is z2.
  assign mid   = z0_q ^ z1_q ^ half_p;
  assign y_mul = PW'(z0_q) ^ (PW'(mid) << H) ^ (PW'(half_p) << WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      z0_q        <= '0;
      z1_q        <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mul_io.in_valid) begin
            a_q        <= mul_io.a;
            b_q        <= mul_io.b;
            in_ready_q <= 1'b0;
            state_q    <= StMulL;
          end
        end
        StMulL: begin
          z0_q    <= half_p;
          state_q <= StMulM;
        end
        StMulM: begin
          z1_q    <= half_p;
          state_q <= StMulH;
        end
        StMulH: begin
          y_q <= y_mul;
`ifdef OKA_MOD_REDUCE_EN
          state_q <= StRed;
`else
          state_q     <= StDone;
          out_valid_q <= 1'b1;
`endif
        end
`ifdef OKA_MOD_REDUCE_EN
        StRed: begin
          y_q         <= PW'(clmul_reduce(MaxPw'(y_q), POLY, WIDTH));
          state_q     <= StDone;
          out_valid_q <= 1'b1;
        end
`endif
        StDone: begin
          if (mul_io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mul_io.in_ready  = in_ready_q;
  assign mul_io.out_valid = out_valid_q;
  assign mul_io.y         = y_q;

endmodule

// File: tb/tb_oka_mul_seq.sv
// Self-checking bench: W=8/16/32 instances run in lockstep against a carry-less reference model.
module tb_oka_mul_seq;
`ifdef OKA_MOD_REDUCE_EN
  localparam int ExpLat = 4;
`else
  localparam int ExpLat = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a_w = '0;
  logic [31:0] b_w = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  oka_mul_seq_if #(.WIDTH(8))  if8 ();
  oka_mul_seq_if #(.WIDTH(16)) if16 ();
  oka_mul_seq_if #(.WIDTH(32)) if32 ();

  assign if8.in_valid   = in_valid;
  assign if8.out_ready  = out_ready;
  assign if8.a          = a_w[7:0];
  assign if8.b          = b_w[7:0];
  assign if16.in_valid  = in_valid;
  assign if16.out_ready = out_ready;
  assign if16.a         = a_w[15:0];
  assign if16.b         = b_w[15:0];
  assign if32.in_valid  = in_valid;
  assign if32.out_ready = out_ready;
  assign if32.a         = a_w;
  assign if32.b         = b_w;

  oka_mul_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .mul_io(if8));
  oka_mul_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .mul_io(if16));
  oka_mul_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .mul_io(if32));

  // Shift-and-add over GF(2), then polynomial long division by x^w + 0x2B when reducing.
  function automatic logic [63:0] ref_y(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] mask, am, bm, p;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, a} & mask;
    bm   = {32'd0, b} & mask;
    p    = '0;
    for (int i = 0; i < w; i++) if (am[i]) p = p ^ (bm << i);
`ifdef OKA_MOD_REDUCE_EN
    for (int k = 2 * w - 2; k >= w; k--)
      if (p[k]) p = p ^ (((64'd1 << w) | 64'h2B) << (k - w));
`endif
    return p;
  endfunction

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
    int guard;
    guard = 0;
    while (!if16.in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    a_w = av;
    b_w = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_w = $urandom;
    b_w = $urandom;
    lat = 0;
    while (!if16.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input int lat);
    logic [63:0] e;
    checks++;
    if (lat !== ExpLat) begin
      failures++;
      $display("FAIL %s_latency a=%h b=%h got=%0d exp=%0d", tag, av, bv, lat, ExpLat);
    end
    e = ref_y(av, bv, 8);
    checks++;
    if (64'(if8.y) !== e) begin
      failures++;
      $display("FAIL %s_w8 a=%h b=%h got=%h exp=%h", tag, av, bv, if8.y, e);
    end
    e = ref_y(av, bv, 16);
    checks++;
    if (64'(if16.y) !== e) begin
      failures++;
      $display("FAIL %s_w16 a=%h b=%h got=%h exp=%h", tag, av, bv, if16.y, e);
    end
    e = ref_y(av, bv, 32);
    checks++;
    if (64'(if32.y) !== e) begin
      failures++;
      $display("FAIL %s_w32 a=%h b=%h got=%h exp=%h", tag, av, bv, if32.y, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({if8.in_ready, if16.in_ready, if32.in_ready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=111", {if8.in_ready, if16.in_ready, if32.in_ready});
    end
    checks++;
    if ({if8.out_valid, if16.out_valid, if32.out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=000",
               {if8.out_valid, if16.out_valid, if32.out_valid});
    end
    checks++;
    if ((64'(if8.y) | 64'(if16.y) | 64'(if32.y)) !== 64'd0) begin
      failures++;
      $display("FAIL reset_y got=%h/%h/%h exp=0", if8.y, if16.y, if32.y);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat;
    do_op(32'h0003, 32'h0003, lat);
    check_all("dir_3x3", 32'h0003, 32'h0003, lat);
    checks++;
    if (64'(if16.y) !== 64'h5) begin
      failures++;
      $display("FAIL dir_3x3_const got=%h exp=5", if16.y);
    end
    finish_op();
`ifdef OKA_MOD_REDUCE_EN
    do_op(32'h8000, 32'h0002, lat);
    check_all("dir_red_x16", 32'h8000, 32'h0002, lat);
    checks++;
    if (64'(if16.y) !== 64'h2B) begin
      failures++;
      $display("FAIL dir_red_x16_const got=%h exp=2b", if16.y);
    end
    finish_op();
    do_op(32'h0001, 32'h1234, lat);
    check_all("dir_red_one", 32'h0001, 32'h1234, lat);
    checks++;
    if (64'(if16.y) !== 64'h1234) begin
      failures++;
      $display("FAIL dir_red_one_const got=%h exp=1234", if16.y);
    end
    finish_op();
`else
    do_op(32'hFFFF, 32'hFFFF, lat);
    check_all("dir_ones", 32'hFFFF, 32'hFFFF, lat);
    checks++;
    if (64'(if16.y) !== 64'h5555_5555) begin
      failures++;
      $display("FAIL dir_ones_const got=%h exp=55555555", if16.y);
    end
    finish_op();
    do_op(32'h8000, 32'h8000, lat);
    check_all("dir_msb", 32'h8000, 32'h8000, lat);
    checks++;
    if (64'(if16.y) !== 64'h4000_0000) begin
      failures++;
      $display("FAIL dir_msb_const got=%h exp=40000000", if16.y);
    end
    finish_op();
`endif
  endtask

  task automatic test_random();
    int          lat;
    logic [31:0] av, bv;
    for (int n = 0; n < 1000; n++) begin
      case (n)
        0:       begin av = '0;      bv = '0;      end
        1:       begin av = '1;      bv = '1;      end
        2:       begin av = '1;      bv = $urandom; end
        3:       begin av = $urandom; bv = '0;     end
        default: begin av = $urandom; bv = $urandom; end
      endcase
      do_op(av, bv, lat);
      check_all("rand", av, bv, lat);
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [63:0] e;
    logic [31:0] av, bv;
    av = $urandom;
    bv = $urandom;
    e  = ref_y(av, bv, 16);
    do_op(av, bv, lat);
    check_all("bp", av, bv, lat);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a_w = $urandom;
      b_w = $urandom;
      @(posedge clk); #1;
      checks++;
      if (64'(if16.y) !== e || if16.out_valid !== 1'b1 || if16.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d y=%h ov=%b ir=%b exp y=%h ov=1 ir=0",
                 c, if16.y, if16.out_valid, if16.in_ready, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release ov=%b ir=%b exp ov=0 ir=1", if16.out_valid, if16.in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (if16.out_valid !== 1'b0 || 64'(if16.y) !== e) begin
        failures++;
        $display("FAIL bp_idle cyc=%0d ov=%b y=%h exp ov=0 y=%h", c, if16.out_valid, if16.y, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [31:0] av, bv;
    do_op(32'h00FF, 32'h0003, lat);
    check_all("rm_pre", 32'h00FF, 32'h0003, lat);
    finish_op();
    a_w = $urandom;
    b_w = $urandom;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({if8.in_ready, if16.in_ready, if32.in_ready} !== 3'b111 ||
        {if8.out_valid, if16.out_valid, if32.out_valid} !== 3'b000 ||
        (64'(if8.y) | 64'(if16.y) | 64'(if32.y)) !== 64'd0) begin
      failures++;
      $display("FAIL rm_abort ir16=%b ov16=%b y16=%h exp ir=1 ov=0 y=0",
               if16.in_ready, if16.out_valid, if16.y);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({if8.out_valid, if16.out_valid, if32.out_valid} !== 3'b000) begin
        failures++;
        $display("FAIL rm_no_pulse cyc=%0d got=%b exp=000", c,
                 {if8.out_valid, if16.out_valid, if32.out_valid});
      end
    end
    av = $urandom;
    bv = $urandom;
    do_op(av, bv, lat);
    check_all("rm_post", av, bv, lat);
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog time limit reached got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
